systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Upstream staging block for the systolic MAC array: buffers an N x K matrix A and a K x N matrix B, then streams them into the array edges with diagonal skew.
- A rows feed the west edge. B columns feed the north edge.
- Each lane drives one edge PE's A_in/B_in, with a matching per-lane valid.
- The PEs then accumulate C = A x B.

Parameters:
- N, 4, array dimension (number of A lanes and number of B lanes)
- K, 4, inner (reduction) dimension; number of valid beats per lane
- DATA_W, 8, element width, signed two's complement
- ADDR_W, $clog2(N*K), write address width (derived, not overridable)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  buffer write strobe; honoured only in IDLE
- wr_sel  in  1  0 = write matrix A, 1 = write matrix B
- wr_addr  in  ADDR_W  A: row*K+col; B: k*N+col
- wr_data  in  DATA_W  signed element
- start  in  1  begin streaming; honoured only in IDLE
- a_out  out  N*DATA_W  lane i in bits [i*DATA_W +: DATA_W], to row-i edge PE A_in
- a_valid  out  N  per-lane valid for a_out
- b_out  out  N*DATA_W  lane j in bits [j*DATA_W +: DATA_W], to column-j edge PE B_in
- b_valid  out  N  per-lane valid for b_out
- busy  out  1  high while streaming
- done  out  1  one-cycle pulse after the last beat

Behaviour:
- Reset (async, any state):
  - state = IDLE, step counter = 0.
  - a_out, b_out, a_valid, b_valid, busy, done all = 0.
  - Both buffers cleared to 0.
- FSM states:
  - IDLE: accepts writes and start.
  - STREAM: outputs skewed data.
  - FINISH: lasts exactly one cycle, done=1, then returns to IDLE.
- Writes:
  - In IDLE, wr_en=1 stores wr_data at the rising edge.
  - Ignored when wr_addr >= N*K.
  - Ignored in STREAM and FINISH; buffer contents are unchanged.
  - Buffers persist across runs, so start may be re-issued without reloading.
- Start:
  - Start sampled high in IDLE at edge e0 → STREAM, step t=0.
  - start=1 together with wr_en=1 in the same IDLE cycle: the write commits first and is visible to step 0.
  - start outside IDLE is ignored.
- Skew, all outputs registered. Step t is visible in the cycle after edge e0+t, for t = 0 .. K+N-2:
  - A lane i: valid iff 0 <= t-i < K; data = A[i][t-i].
  - B lane j: valid iff 0 <= t-j < K; data = B[t-j][j].
  - Invalid lanes drive data 0.
- Latency: lane 0's first beat appears one cycle after start is sampled; each lane carries exactly K valid beats.
- Total stream length: K+N-1 cycles.
- busy = 1 exactly during the K+N-1 stream cycles.
- At edge e0+K+N-1:
  - All valids and data go to 0, busy=0, done=1 for one cycle.
  - The next cycle is IDLE with done=0.
- No backpressure: the array consumes one beat per cycle unconditionally.
- Arithmetic: none. Data passes bit-exact, including sign.
- Reset mid-stream: outputs go to 0 immediately; no done pulse.

Test Plan:
1. Build with N=2, K=2. Load A=[[1,2],[3,4]], B=[[5,6],[7,8]], then start. Required response:
   - Cycle e0+1: a = {lane0=1, lane1=-}, b = {lane0=5, lane1=-}.
   - Cycle e0+2: a = {2, 3}, b = {7, 6}.
   - Cycle e0+3: a = {-, 4}, b = {-, 8}.
   - Cycle e0+4: done=1, busy=0.
   - "-" means valid=0 and data 0.
2. Defaults N=K=4, with A[0][*]=10,-20,30,-40 and B[*][0]=2,3,-4,5. Required response:
   - Lane 0 emits 10,-20,30,-40 and 2,3,-4,5 on steps 0-3, as two's complement (0xEC = -20).
   - Lane 3 is first valid at step 3.
   - busy is high for 7 cycles.
3. Pulse start in STREAM and issue wr_en to A addr 0 with 99 mid-stream. Required response:
   - Stream timing is unchanged.
   - A rerun after done still outputs the original A[0][0].
4. Assert reset at step 2. Required response:
   - All outputs are 0 within the same cycle, with no done pulse.
   - A subsequent start streams zeros with correct valid timing (buffers were cleared).
5. Write to wr_addr = N*K (out of range) with 0x7F. Required response: no buffer change, and A[0][0] still reads back correctly on stream.
6. Issue start twice without reloading. Required response: identical output sequences, and done pulses exactly once per run.

Source files
------------

// File: rtl/systolic_feeder.sv
// Staging buffers for matrices A (N x K) and B (K x N), streamed into the west
// and north edges of the systolic MAC array with a one-cycle-per-lane skew.
module systolic_feeder #(
    parameter int N = 4,
    parameter int K = 4,
    parameter int DATA_W = 8,
    localparam int ADDR_W = $clog2(N*K)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  start,
    output logic [N*DATA_W-1:0]   a_out,
    output logic [N-1:0]          a_valid,
    output logic [N*DATA_W-1:0]   b_out,
    output logic [N-1:0]          b_valid,
    output logic                  busy,
    output logic                  done
);
    localparam int DEPTH = N*K;
    localparam int STEP_W = $clog2(K+N);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(K+N-2);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state;
    logic [STEP_W-1:0]    step;
    logic [DATA_W-1:0]    a_mem [DEPTH];
    logic [DATA_W-1:0]    b_mem [DEPTH];
    logic                 wr_ok;
    logic [STEP_W-1:0]    next_step;
    logic [N*DATA_W-1:0]  a_next;
    logic [N*DATA_W-1:0]  b_next;
    logic [N-1:0]         a_valid_next;
    logic [N-1:0]         b_valid_next;
    int                   step_int;
    int                   lag;
    logic [ADDR_W-1:0]    a_idx;
    logic [ADDR_W-1:0]    b_idx;

    assign wr_ok     = (state == IDLE) && wr_en && ({1'b0, wr_addr} < DEPTH_V);
    assign next_step = (state == IDLE) ? '0 : step + STEP_W'(1);

    // Buffer write port; contents survive between runs until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (wr_ok) begin
            if (wr_sel) begin
                b_mem[wr_addr] <= wr_data;
            end else begin
                a_mem[wr_addr] <= wr_data;
            end
        end
    end

    // Lane contents for next_step; a write in the start cycle is forwarded into step 0
    always_comb begin
        a_next       = '0;
        b_next       = '0;
        a_valid_next = '0;
        b_valid_next = '0;
        step_int     = 32'(next_step);
        lag          = 0;
        a_idx        = '0;
        b_idx        = '0;
        for (int i = 0; i < N; i++) begin
            lag = step_int - i;
            if (lag >= 0 && lag < K) begin
                a_idx = ADDR_W'(i*K + lag);
                b_idx = ADDR_W'(lag*N + i);
                a_valid_next[i] = 1'b1;
                b_valid_next[i] = 1'b1;
                a_next[i*DATA_W +: DATA_W] = (wr_ok && !wr_sel && wr_addr == a_idx) ? wr_data : a_mem[a_idx];
                b_next[i*DATA_W +: DATA_W] = (wr_ok && wr_sel && wr_addr == b_idx) ? wr_data : b_mem[b_idx];
            end else begin
                a_valid_next[i] = 1'b0;
                b_valid_next[i] = 1'b0;
            end
        end
    end

    // Sequencer with registered edge outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            step    <= '0;
            a_out   <= '0;
            b_out   <= '0;
            a_valid <= '0;
            b_valid <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= STREAM;
                        step    <= '0;
                        a_out   <= a_next;
                        b_out   <= b_next;
                        a_valid <= a_valid_next;
                        b_valid <= b_valid_next;
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                STREAM: begin
                    if (step == LAST_STEP) begin
                        state   <= FINISH;
                        a_out   <= '0;
                        b_out   <= '0;
                        a_valid <= '0;
                        b_valid <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        step    <= next_step;
                        a_out   <= a_next;
                        b_out   <= b_next;
                        a_valid <= a_valid_next;
                        b_valid <= b_valid_next;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    step    <= '0;
                    a_out   <= '0;
                    b_out   <= '0;
                    a_valid <= '0;
                    b_valid <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench: a square (4x4) and a non-square (N=3,K=2) feeder share one
// stimulus stream; a matrix-level model predicts every output cycle of both.
module tb_systolic_feeder;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        start;

    logic [31:0] a_out0, b_out0;
    logic [3:0]  a_valid0, b_valid0;
    logic        busy0, done0;
    logic [23:0] a_out1, b_out1;
    logic [2:0]  a_valid1, b_valid1;
    logic        busy1, done1;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  av;
        logic [31:0] b;
        logic [3:0]  bv;
        logic        busy;
        logic        done;
    } rec_t;

    rec_t       q0[$];
    rec_t       q1[$];
    logic [7:0] ma [2][16];
    logic [7:0] mb [2][16];
    int         remaining [2];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    systolic_feeder #(.N(4), .K(4), .DATA_W(8)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .a_out(a_out0), .a_valid(a_valid0), .b_out(b_out0), .b_valid(b_valid0),
        .busy(busy0), .done(done0)
    );

    systolic_feeder #(.N(3), .K(2), .DATA_W(8)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr[2:0]), .wr_data(wr_data), .start(start),
        .a_out(a_out1), .a_valid(a_valid1), .b_out(b_out1), .b_valid(b_valid1),
        .busy(busy1), .done(done1)
    );

    function automatic int cfg_n(input int c);
        return (c == 0) ? 4 : 3;
    endfunction

    function automatic int cfg_k(input int c);
        return (c == 0) ? 4 : 2;
    endfunction

    // Edge-lane contents for step t: row i of A meets element t-i, column j of B likewise
    function automatic rec_t beat(input int c, input int t);
        rec_t r;
        int   n;
        int   k;
        r = '0;
        n = cfg_n(c);
        k = cfg_k(c);
        r.busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (t - i >= 0 && t - i < k) begin
                r.av[i] = 1'b1;
                r.a[i*DW +: DW] = ma[c][i*k + (t - i)];
                r.bv[i] = 1'b1;
                r.b[i*DW +: DW] = mb[c][(t - i)*n + i];
            end
        end
        return r;
    endfunction

    task automatic push(input int c, input rec_t r);
        if (c == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    // One rising edge of the behavioural model for configuration c
    task automatic model_edge(input int c);
        int   n;
        int   k;
        int   addr;
        rec_t r;
        n = cfg_n(c);
        k = cfg_k(c);
        addr = (c == 0) ? int'(wr_addr) : int'(wr_addr[2:0]);
        if (remaining[c] > 0) begin
            remaining[c] = remaining[c] - 1;
        end else begin
            if (wr_en && addr < n*k) begin
                if (wr_sel) mb[c][addr] = wr_data;
                else ma[c][addr] = wr_data;
            end
            if (start) begin
                for (int t = 0; t <= k + n - 2; t++) push(c, beat(c, t));
                r = '0;
                r.done = 1'b1;
                push(c, r);
                remaining[c] = k + n;
            end
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        for (int c = 0; c < 2; c++) begin
            remaining[c] = 0;
            for (int i = 0; i < 16; i++) begin
                ma[c][i] = 8'd0;
                mb[c][i] = 8'd0;
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_clear();
            end else begin
                model_edge(0);
                model_edge(1);
            end
        end
    end

    // Monitor: every falling edge, each DUT must present the next expected cycle (idle = all zero)
    initial begin
        rec_t exp_r;
        rec_t act_r;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                exp_r = '0;
                if (c == 0) begin
                    if (q0.size() > 0) exp_r = q0.pop_front();
                    act_r = {a_out0, a_valid0, b_out0, b_valid0, busy0, done0};
                end else begin
                    if (q1.size() > 0) exp_r = q1.pop_front();
                    act_r = {8'd0, a_out1, 1'b0, a_valid1, 8'd0, b_out1, 1'b0, b_valid1, busy1, done1};
                end
                checks++;
                if (act_r !== exp_r) begin
                    errors++;
                    $display("FAIL cfg%0d_cycle @%0t actual a=%h av=%b b=%h bv=%b busy=%b done=%b required a=%h av=%b b=%h bv=%b busy=%b done=%b",
                             c, $time, act_r.a, act_r.av, act_r.b, act_r.bv, act_r.busy, act_r.done,
                             exp_r.a, exp_r.av, exp_r.b, exp_r.bv, exp_r.busy, exp_r.done);
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        checks++;
        if ({a_out0, a_valid0, b_out0, b_valid0, busy0, done0,
             a_out1, a_valid1, b_out1, b_valid1, busy1, done1} !== '0) begin
            errors++;
            $display("FAIL reset_state_%s @%0t actual a0=%h av0=%b b0=%h bv0=%b busy0=%b done0=%b a1=%h av1=%b b1=%h bv1=%b busy1=%b done1=%b required all zero",
                     tag, $time, a_out0, a_valid0, b_out0, b_valid0, busy0, done0,
                     a_out1, a_valid1, b_out1, b_valid1, busy1, done1);
        end
    endtask

    task automatic wait_done(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done0 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_done @%0t actual no done within %0d cycles required done pulse", $time, limit);
        end
    endtask

    task automatic cyc(input logic en, input logic sel, input logic [3:0] addr,
                       input logic [7:0] data, input logic st);
        wr_en   = en;
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = data;
        start   = st;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    task automatic wr(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        cyc(1'b1, sel, addr, data, 1'b0);
    endtask

    task automatic go();
        cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd0; start = 1'b0;
        #1 check_reset_state("initial");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        for (int i = 0; i < 16; i++) begin
            wr(1'b0, 4'(i), 8'($urandom));
            wr(1'b1, 4'(i), 8'($urandom));
        end
        wr(1'b0, 4'd0, 8'd10);
        wr(1'b0, 4'd1, 8'hEC);
        wr(1'b0, 4'd2, 8'd30);
        wr(1'b0, 4'd3, 8'hD8);
        wr(1'b1, 4'd0, 8'd2);
        wr(1'b1, 4'd4, 8'd3);
        wr(1'b1, 4'd8, 8'hFC);
        wr(1'b1, 4'd12, 8'd5);
        go();
        wait_done(20);
        idle(3);

        // start and write while streaming are both ignored
        go();
        idle(2);
        go();
        wr(1'b0, 4'd0, 8'd99);
        idle(10);
        go();
        idle(10);

        // addresses 6 and 7 lie outside the 3x2 buffers
        wr(1'b0, 4'd6, 8'h7F);
        wr(1'b0, 4'd15, 8'h7F);
        wr(1'b1, 4'd7, 8'h7F);
        go();
        idle(10);

        // back-to-back reruns without reloading
        go();
        idle(9);
        go();
        idle(10);

        // write and start in the same cycle
        cyc(1'b1, 1'b0, 4'd0, 8'h81, 1'b1);
        idle(10);

        // reset while step 2 is on the lanes, then stream cleared buffers
        go();
        idle(2);
        reset = 1'b1;
        #1 check_reset_state("midstream");
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);
        go();
        idle(10);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 2) != 0), 1'($urandom), 4'($urandom), 8'($urandom),
                ($urandom_range(0, 7) == 0));
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
